shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Parametrised multi-cycle shift unit for the datapath, generalising the fixed left-by-2 jump-target shift to arbitrary width, arbitrary shift amount and three shift modes. It shifts `STEP` bits per cycle, so a wide shifter costs no barrel-shifter area. A start/busy/done handshake lets the EX stage stall on it. It serves variable `sll/srl/sra` and `sllv/srlv/srav` instructions.

## Interface
- `WIDTH`, 32: data width; power of two, ≥ 4.
- `SHAMT_W`, `$clog2(WIDTH)`: shift-amount width.
- `STEP`, 4: maximum bits shifted per cycle; power of two, 1 ≤ `STEP` ≤ `WIDTH`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; accepted only when `busy` = 0.
- `mode` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR/passthrough (see Configuration).
- `shamt` in `SHAMT_W`: shift amount, 0..`WIDTH`-1.
- `in` in `WIDTH`: operand.
- `busy` out 1: shifting in progress; new `start` is ignored.
- `done` out 1: one-cycle pulse; `out` is valid.
- `out` out `WIDTH`: result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE/DONE + `start`:**
  - Latch `in` into the working register, and latch `mode`.
  - Set `rem` = `shamt`.
  - Next state is SHIFT if `shamt` ≠ 0. Otherwise it is DONE.
- **SHIFT:**
  - Each cycle, shift the working register by k = min(`STEP`, `rem`) using the latched mode, then set `rem` -= k.
  - When `rem` reaches 0 this cycle, go to DONE.
  - `start` is ignored.
- **DONE:**
  - `done` = 1 for exactly one cycle.
  - Next state is IDLE, unless `start` = 1. In that case the new request is accepted back-to-back and the normal IDLE rules apply.
- `busy` = 1 exactly while in SHIFT.
- Mode fill rules:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: MSB replicated.
- Result is bit-exact to a single-cycle shift by `shamt`.
- `out` = working register.
  - It is valid while `done` = 1.
  - It is held unchanged in IDLE until the next accepted `start`.
  - Its value during SHIFT is undefined for consumers.
- `shamt` is `SHAMT_W` bits wide, so a shift ≥ `WIDTH` cannot occur.
- `start` is level-sampled. Holding it high makes back-to-back requests, each accepted on a non-busy cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `out` 0, `rem` 0.
- Latency: with `start` sampled at the end of cycle 0 and N = ceil(`shamt`/`STEP`), `done` is high in cycle N+1.
  - `shamt` = 0 gives `done` in cycle 1, with `busy` never asserted.
- `busy` is high in cycles 1..N.
- Throughput: one result every N+1 cycles with back-to-back starts.
- Reset mid-operation: at the next edge the unit returns to IDLE, `out` = 0, no `done` pulse, and the in-flight request is dropped.
- Reset and `start` in the same cycle: reset wins and the request is not accepted.
- Inputs `in`, `mode`, `shamt` only need to be stable in the cycle `start` is sampled.

## Configuration
- Macro: `SHIFT_ROTATE_EN`.
- **Defined:** `mode` 11 = rotate right (ROR). Bits leaving the LSB enter the MSB, with latency as for the other modes.
- **Undefined:**
  - `mode` 11 is passthrough: `out` = `in`, treated as `shamt` = 0, with `done` in cycle 1.
  - No rotate logic is synthesised.

## Structure
- Shared package `shift_pkg` holds:
  - mode encodings `SH_SLL`, `SH_SRL`, `SH_SRA`, `SH_ROR`;
  - FSM state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- The ALU decoder imports the same mode constants.
- One combinational sub-module, `shift_step`: shifts a `WIDTH` vector by 0..`STEP` bits in a given mode.
- The top holds the FSM, the `rem` counter and the working register.

## Test plan
Parameters: `WIDTH`=32, `STEP`=4. Cycle numbers are relative to the `start` cycle.
1. SLL, `in`=0x0000_0001, `shamt`=5 → `busy` in cycles 1–2, `done` in cycle 3, `out`=0x0000_0020.
2. SRA, `in`=0x8000_0000, `shamt`=31 → `done` in cycle 9, `out`=0xFFFF_FFFF. SRL with the same operands gives 0x0000_0001.
3. SRL, `in`=0x1234_5678, `shamt`=0 → `done` in cycle 1, `out`=0x1234_5678, `busy` never high.
4. `start` pulsed during `busy` (`in`=0xFFFF_FFFF) → ignored, original result unchanged. Then `start` held high in the DONE cycle → second request accepted immediately, its `done` N+1 cycles later.
5. `reset` asserted in cycle 2 of `shamt`=20 → next cycle `busy`=0, `out`=0, and no `done` for that request.
6. `mode`=11, `in`=0x0000_000F, `shamt`=4:
   - with `SHIFT_ROTATE_EN` → `out`=0xF000_0000 in cycle 2;
   - without it → `out`=0x0000_000F in cycle 1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift unit and the ALU decoder.
// Mode 11 is rotate-right when SHIFT_ROTATE_EN is defined, passthrough otherwise.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts a WIDTH vector by 0..STEP bits in one mode.
// Rotate support is compiled in only with SHIFT_ROTATE_EN.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    // NOTE: result gets a default before any branch so no path leaves it unassigned (no latch).
    result = data;
    for (int k = 1; k <= STEP; k++) begin
      if (amt == AMT_W'(k)) begin
        case (mode)
          SH_SLL:  result = data << k;
          SH_SRL:  result = data >> k;
          SH_SRA:  result = $unsigned($signed(data) >>> k);
`ifdef SHIFT_ROTATE_EN
          SH_ROR:  result = (data >> k) | (data << (WIDTH - k));
`endif
          default: result = data;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: STEP bits per cycle, start/busy/done handshake.
// Define SHIFT_ROTATE_EN to make mode 11 a rotate-right; otherwise it is passthrough.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  localparam int AMT_W = $clog2(STEP + 1);

  shift_state_t       state;
  shift_mode_t        mode_q;
  logic [SHAMT_W-1:0] rem;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step_result;
  logic [AMT_W-1:0]   k;
  logic [SHAMT_W-1:0] shamt_eff;

  // Without rotate support, mode 11 behaves as a zero-length shift.
  always_comb begin
`ifdef SHIFT_ROTATE_EN
    shamt_eff = shamt;
`else
    shamt_eff = (mode == SH_ROR) ? '0 : shamt;
`endif
  end

  always_comb begin
    if (int'(rem) >= STEP) k = AMT_W'(STEP);
    else                   k = AMT_W'(rem);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data   (work),
    .amt    (k),
    .mode   (mode_q),
    .result (step_result)
  );

  // NOTE: the working register is an ordinary reset flop, not a memory; out must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= SH_SLL;
      rem    <= '0;
      work   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            work   <= in;
            mode_q <= shift_mode_t'(mode);
            rem    <= shamt_eff;
            if (shamt_eff != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work <= step_result;
          rem  <= rem - SHAMT_W'(k);
          if (rem == SHAMT_W'(k)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out = work;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=32, STEP=4) with a result scoreboard.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [31:0] d_in;
  logic        busy;
  logic        done;
  logic [31:0] d_out;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] sb[$];

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .in    (d_in),
    .busy  (busy),
    .done  (done),
    .out   (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle reference shift.
  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [4:0] s,
                                            input logic [31:0] d);
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return ROT ? ((d >> s) | (d << (6'd32 - {1'b0, s}))) : d;
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(posedge clk) begin
    #2;
    if (done === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else                check("result", d_out, sb.pop_front());
    end
  end

  // Drives a request in the current cycle (cycle 0) and checks busy/done through cycle N+1.
  // Returns in the DONE cycle so the caller can chain a back-to-back request.
  task automatic run_op(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d,
                        input string tag);
    int n;
    int eff;
    eff = (m == 2'b11 && !ROT) ? 0 : int'(s);
    n = (eff + 3) / 4;
    start = 1'b1; mode = m; shamt = s; d_in = d;
    sb.push_back(ref_shift(m, s, d));
    tick();
    start = 1'b0; d_in = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    for (int c = 1; c <= n + 1; c++) begin
      check({tag, "_busy"}, 32'(busy), 32'(c <= n));
      check({tag, "_done"}, 32'(done), 32'(c == n + 1));
      if (c < n + 1) tick();
    end
  endtask

  initial begin : stim
    int c;
    logic [31:0] held;
    reset = 1'b1; start = 1'b0; mode = 2'b00; shamt = '0; d_in = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", d_out, 32'd0);
    reset = 1'b0;
    tick();

    // Plan item 1: SLL by 5.
    run_op(2'b00, 5'd5, 32'h0000_0001, "sll5");
    check("sll5_out", d_out, 32'h0000_0020);
    tick();
    // Plan item 2: SRA / SRL by 31.
    run_op(2'b10, 5'd31, 32'h8000_0000, "sra31");
    check("sra31_out", d_out, 32'hFFFF_FFFF);
    tick();
    run_op(2'b01, 5'd31, 32'h8000_0000, "srl31");
    check("srl31_out", d_out, 32'h0000_0001);
    tick();
    // Plan item 3: zero shift.
    run_op(2'b01, 5'd0, 32'h1234_5678, "srl0");
    check("srl0_out", d_out, 32'h1234_5678);
    held = d_out;
    tick(); tick(); tick();
    check("idle_hold", d_out, held);

    // Plan item 4: start during busy is ignored, then back-to-back from DONE.
    start = 1'b1; mode = 2'b00; shamt = 5'd20; d_in = 32'h0000_0001;
    sb.push_back(32'h0010_0000);
    tick();
    check("ign_busy1", 32'(busy), 32'd1);
    start = 1'b1; mode = 2'b01; shamt = 5'd0; d_in = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    c = 2;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    check("ign_done_cycle", 32'(c), 32'd6);
    check("ign_out", d_out, 32'h0010_0000);
    run_op(2'b01, 5'd8, 32'hF000_0000, "b2b");
    check("b2b_out", d_out, 32'h00F0_0000);
    tick();

    // Plan item 5: reset in cycle 2 of a 20-bit shift drops the request.
    start = 1'b1; mode = 2'b00; shamt = 5'd20; d_in = 32'h0000_0003;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_out", d_out, 32'd0);
    check("rmid_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rmid_nodone", 32'(done), 32'd0);
    end

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; mode = 2'b01; shamt = 5'd0; d_in = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rst_start_done", 32'(done), 32'd0);
    check("rst_start_out", d_out, 32'd0);
    tick();
    check("rst_start_done2", 32'(done), 32'd0);

    // Plan item 6: mode 11.
    run_op(2'b11, 5'd4, 32'h0000_000F, "m11");
    check("m11_out", d_out, ROT ? 32'hF000_0000 : 32'h0000_000F);
    tick();

    // Random operations, chained back-to-back on every other one.
    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), 5'($urandom), $urandom, "rnd");
      if (i[0]) tick();
    end
    tick(); tick(); tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
